// File: rtl/mips_pkg.sv
// Shared MIPS core types and constants.
// Instruction field positions, bubble encoding and fetch FSM states.
package mips_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0;

   localparam int RS_MSB = 25;
   localparam int RS_LSB = 21;
   localparam int RT_MSB = 20;
   localparam int RT_LSB = 16;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// Generic pipeline register: load / hold / flush-to-bubble.
// Flush wins over load; reset leaves a bubble.
module if_id_reg
   import mips_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              flush,
   input  logic [31:0]       instr_in,
   input  logic [ADDR_W-1:0] pc4_in,
   output logic [31:0]       instr,
   output logic [ADDR_W-1:0] pc4,
   output logic              valid
);

   logic [31:0]       instr_q, instr_d;
   logic [ADDR_W-1:0] pc4_q, pc4_d;
   logic              valid_q, valid_d;

   always_comb begin
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      if (flush) begin
         instr_d = NOP_INSTR;
         pc4_d   = '0;
         valid_d = 1'b0;
      end else if (load) begin
         instr_d = instr_in;
         pc4_d   = pc4_in;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_q <= NOP_INSTR;
         pc4_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
      end
   end

   assign instr = instr_q;
   assign pc4   = pc4_q;
   assign valid = valid_q;

endmodule

// File: rtl/fetch_if_id_stage.sv
// Fetch stage + IF/ID register: PC, imem request, stall/branch handling.
// Optional perf counters enabled by FETCH_PERF_CNT_EN.
module fetch_if_id_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          ADDR_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_target,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ready,
   input  logic [31:0]       imem_rdata,
   output logic [31:0]       if_id_instr,
   output logic [ADDR_W-1:0] if_id_pc4,
   output logic              if_id_valid,
   output logic [4:0]        if_id_rs,
`ifdef FETCH_PERF_CNT_EN
   output logic [4:0]        if_id_rt,
   output logic [31:0]       perf_stall_cycles,
   output logic [31:0]       perf_bubbles
`else
   output logic [4:0]        if_id_rt
`endif
);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [31:0]       hb_instr_q, hb_instr_d;
   logic [ADDR_W-1:0] hb_pc4_q, hb_pc4_d;
   logic              req_q, req_d;

   logic              reg_load;
   logic              reg_flush;
   logic [31:0]       reg_instr;
   logic [ADDR_W-1:0] reg_pc4;
   logic [ADDR_W-1:0] pc_plus4;

   assign pc_plus4 = pc_q + ADDR_W'(4);

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      hb_instr_d = hb_instr_q;
      hb_pc4_d   = hb_pc4_q;
      reg_load   = 1'b0;
      reg_flush  = 1'b0;
      reg_instr  = imem_rdata;
      reg_pc4    = pc_plus4;
      unique case (state_q)
         BOOT: begin
            state_d = FETCH;
            if (branch_taken) begin
               pc_d      = branch_target;
               reg_flush = 1'b1;
            end
         end
         FETCH: begin
            if (branch_taken) begin
               pc_d      = branch_target;
               reg_flush = 1'b1;
            end else if (imem_ready && !stall) begin
               reg_load = 1'b1;
               pc_d     = pc_plus4;
            end else if (imem_ready) begin
               hb_instr_d = imem_rdata;
               hb_pc4_d   = pc_plus4;
               state_d    = HOLD;
            end else if (!stall) begin
               reg_flush = 1'b1;
            end
         end
         HOLD: begin
            if (branch_taken) begin
               pc_d       = branch_target;
               reg_flush  = 1'b1;
               hb_instr_d = NOP_INSTR;
               hb_pc4_d   = '0;
               state_d    = FETCH;
            end else if (!stall) begin
               reg_load   = 1'b1;
               reg_instr  = hb_instr_q;
               reg_pc4    = hb_pc4_q;
               pc_d       = hb_pc4_q;
               hb_instr_d = NOP_INSTR;
               hb_pc4_d   = '0;
               state_d    = FETCH;
            end
         end
         default: state_d = BOOT;
      endcase
      req_d = (state_d == FETCH);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= BOOT;
         pc_q       <= RESET_PC[ADDR_W-1:0];
         hb_instr_q <= NOP_INSTR;
         hb_pc4_q   <= '0;
         req_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         hb_instr_q <= hb_instr_d;
         hb_pc4_q   <= hb_pc4_d;
         req_q      <= req_d;
      end
   end

   if_id_reg #(
      .ADDR_W (ADDR_W)
   ) u_if_id (
      .clk      (clk),
      .rst      (rst),
      .load     (reg_load),
      .flush    (reg_flush),
      .instr_in (reg_instr),
      .pc4_in   (reg_pc4),
      .instr    (if_id_instr),
      .pc4      (if_id_pc4),
      .valid    (if_id_valid)
   );

   assign imem_req  = req_q;
   assign imem_addr = pc_q;
   assign if_id_rs  = if_id_instr[RS_MSB:RS_LSB];
   assign if_id_rt  = if_id_instr[RT_MSB:RT_LSB];

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] bub_cnt_q, bub_cnt_d;

   // Both counters stick at all-ones rather than wrapping.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      bub_cnt_d   = bub_cnt_q;
      if (stall && state_q != BOOT && stall_cnt_q != 32'hFFFF_FFFF)
         stall_cnt_d = stall_cnt_q + 32'd1;
      if (reg_flush && bub_cnt_q != 32'hFFFF_FFFF)
         bub_cnt_d = bub_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
         bub_cnt_q   <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         bub_cnt_q   <= bub_cnt_d;
      end
   end

   assign perf_stall_cycles = stall_cnt_q;
   assign perf_bubbles      = bub_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_if_id_stage.sv
// Scoreboard bench for fetch_if_id_stage: directed + random stimulus.
// Set FETCH_PERF_CNT_EN to also check the perf counters.
module tb_fetch_if_id_stage;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc4;
   logic        if_id_valid;
   logic [4:0]  if_id_rs;
   logic [4:0]  if_id_rt;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_stall_cycles;
   logic [31:0] perf_bubbles;
`endif

   fetch_if_id_stage #(
      .RESET_PC (32'h0),
      .ADDR_W   (32)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .stall             (stall),
      .branch_taken      (branch_taken),
      .branch_target     (branch_target),
      .imem_req          (imem_req),
      .imem_addr         (imem_addr),
      .imem_ready        (imem_ready),
      .imem_rdata        (imem_rdata),
      .if_id_instr       (if_id_instr),
      .if_id_pc4         (if_id_pc4),
      .if_id_valid       (if_id_valid),
      .if_id_rs          (if_id_rs),
`ifdef FETCH_PERF_CNT_EN
      .if_id_rt          (if_id_rt),
      .perf_stall_cycles (perf_stall_cycles),
      .perf_bubbles      (perf_bubbles)
`else
      .if_id_rt          (if_id_rt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        valid;
      logic [31:0] addr;
      logic        req;
      logic [31:0] stalls;
      logic [31:0] bubbles;
   } exp_t;

   exp_t exp_q[$];
   int   n_pass;
   int   n_total;

   // Reference: a fetch unit seen as "booting", "waiting to deliver a
   // captured word", or "issuing" the word at m_pc.
   logic        m_boot;
   logic        m_parked;
   logic [31:0] m_park_instr;
   logic [31:0] m_pc;
   logic [31:0] m_instr;
   logic [31:0] m_pc4;
   logic        m_valid;
   logic [31:0] m_stalls;
   logic [31:0] m_bubbles;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hA5C3_0F1E;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h, expected %h", nm, act, req);
   endtask

   task automatic model_reset();
      m_boot    = 1'b1;
      m_parked  = 1'b0;
      m_pc      = 32'h0;
      m_instr   = 32'h0;
      m_pc4     = 32'h0;
      m_valid   = 1'b0;
      m_stalls  = 0;
      m_bubbles = 0;
   endtask

   task automatic bubble();
      m_instr = 32'h0;
      m_valid = 1'b0;
      m_bubbles++;
   endtask

   task automatic deliver(input logic [31:0] w, input logic [31:0] next);
      m_instr = w;
      m_pc4   = next;
      m_valid = 1'b1;
      m_pc    = next;
   endtask

   // Called at a falling edge: apply inputs, advance model, queue result.
   task automatic step(input logic s, input logic b,
                       input logic [31:0] t, input logic r);
      exp_t e;
      logic [31:0] w;
      w = r ? mem_word(m_pc) : $urandom;
      stall         = s;
      branch_taken  = b;
      branch_target = t;
      imem_ready    = r;
      imem_rdata    = w;
      if (!m_boot && s) m_stalls++;
      if (b) begin
         m_pc     = t;
         m_parked = 1'b0;
         bubble();
      end else if (m_boot) begin
      end else if (m_parked) begin
         if (!s) begin
            deliver(m_park_instr, m_pc + 32'd4);
            m_parked = 1'b0;
         end
      end else if (r && !s) begin
         deliver(w, m_pc + 32'd4);
      end else if (r) begin
         m_parked     = 1'b1;
         m_park_instr = w;
      end else if (!s) begin
         bubble();
      end
      m_boot    = 1'b0;
      e.instr   = m_instr;
      e.pc4     = m_pc4;
      e.valid   = m_valid;
      e.addr    = m_pc;
      e.req     = !m_parked;
      e.stalls  = m_stalls;
      e.bubbles = m_bubbles;
      exp_q.push_back(e);
      @(negedge clk);
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("valid", {31'b0, if_id_valid}, {31'b0, e.valid});
         chk("instr", if_id_instr, e.instr);
         if (e.valid) chk("pc4", if_id_pc4, e.pc4);
         chk("rs", {27'b0, if_id_rs}, {27'b0, e.instr[25:21]});
         chk("rt", {27'b0, if_id_rt}, {27'b0, e.instr[20:16]});
         chk("imem_addr", imem_addr, e.addr);
         chk("imem_req", {31'b0, imem_req}, {31'b0, e.req});
`ifdef FETCH_PERF_CNT_EN
         chk("perf_stall", perf_stall_cycles, e.stalls);
         chk("perf_bubbles", perf_bubbles, e.bubbles);
`endif
      end
   end

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_valid"}, {31'b0, if_id_valid}, 32'h0);
      chk({tag, "_instr"}, if_id_instr, 32'h0);
      chk({tag, "_pc4"}, if_id_pc4, 32'h0);
      chk({tag, "_req"}, {31'b0, imem_req}, 32'h0);
      chk({tag, "_addr"}, imem_addr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
      chk({tag, "_pstall"}, perf_stall_cycles, 32'h0);
      chk({tag, "_pbub"}, perf_bubbles, 32'h0);
`endif
   endtask

   initial begin
      n_pass        = 0;
      n_total       = 0;
      rst           = 1'b0;
      stall         = 1'b0;
      branch_taken  = 1'b0;
      branch_target = 32'h0;
      imem_ready    = 1'b0;
      imem_rdata    = 32'h0;
      #1 rst = 1'b1;
      #1 chk_reset_outputs("reset");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();

      // Boot, then zero-wait fetches up to pc=0x10.
      repeat (5) step(1'b0, 1'b0, 32'h0, 1'b1);
      // Stall 3 cycles at 0x10, then release.
      repeat (3) step(1'b1, 1'b0, 32'h0, 1'b1);
      step(1'b0, 1'b0, 32'h0, 1'b1);
      // Park a word, then branch while stalled.
      step(1'b1, 1'b0, 32'h0, 1'b1);
      step(1'b1, 1'b1, 32'h40, 1'b1);
      step(1'b0, 1'b0, 32'h0, 1'b1);
      // Memory wait for 2 cycles.
      repeat (2) step(1'b0, 1'b0, 32'h0, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b1);
      // Wrap at the top of the address space.
      step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
      repeat (2) step(1'b0, 1'b0, 32'h0, 1'b1);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         step(($urandom % 4) == 0, ($urandom % 8) == 0,
              $urandom, ($urandom % 4) != 0);
      end

      // Enter HOLD, then reset asynchronously mid-cycle.
      step(1'b0, 1'b0, 32'h0, 1'b1);
      step(1'b1, 1'b0, 32'h0, 1'b1);
      #2 rst = 1'b1;
      #1 chk_reset_outputs("async_rst");
      stall      = 1'b0;
      imem_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1);

      @(posedge clk);
      #2;
      chk("queue_drained", exp_q.size(), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
